intr_arbiter: RTL and testbench
===============================

# intr_arbiter

Multi-source interrupt controller in front of the pipelined CPU's single `INT`/`Inta` interrupt pair. It edge-detects `N` peripheral request lines, holds them as pending, applies a software-written mask and selects one source. It raises `INT`, completes the handshake on `Inta`, and blocks further requests until the handler signals end-of-interrupt. The handler reads `vec_id` through the system's memory-mapped I/O decode to identify the source.

## Interface
- `N`, default 8: number of request lines, 2..16.
- `IDW`, default 3: width of `vec_id`; must equal ceil(log2(N)).
- `clk` in 1: system clock, the same clock as the CPU.
- `reset` in 1: synchronous, active-high; every register is set to its reset value on the rising `clk` edge while high.
- `irq_in` in N: peripheral request lines, synchronous to `clk`; a 0→1 transition is a request.
- `mask_we` in 1: one-cycle write strobe for the mask register.
- `mask_wdata` in N: new mask value; bit=1 disables that source.
- `eoi` in 1: one-cycle end-of-interrupt pulse from the handler's MMIO write.
- `Inta` in 1: CPU interrupt acknowledge.
- `INT` out 1: interrupt request to the CPU.
- `vec_id` out IDW: index of the granted source.
- `in_service` out 1: a source has been acknowledged and EOI is not yet seen.
- `pending` out N: pending register.
- `mask` out N: mask register.

## Operation
- Edge detect: `irq_d` <= `irq_in` every cycle. `edge = irq_in & ~irq_d`.
- Pending update: `pending[i]` is set by `edge[i]` and cleared at the grant acknowledge. If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask: written when `mask_we` is high. Masking never clears pending bits. `eligible = pending & ~mask`.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `eligible` != 0, latch the arbitration winner into `vec_id`, set `INT`=1 and go to REQ.
  - REQ: hold `INT` and `vec_id`. When `Inta`=1, clear `pending[vec_id]`, set `INT`=0 and `in_service`=1, and go to SERVICE. Mask changes in REQ do not withdraw the request.
  - SERVICE: `INT` stays 0. On `eoi`=1, set `in_service`=0 and go to IDLE.
- `eoi` outside SERVICE is ignored.
- `Inta` outside REQ is ignored.
- No nesting: at most one source is in service at a time.
- Arbitration in the default build is fixed priority: the lowest eligible index wins.
- Reset mid-operation drops `INT` at the same edge, clears pending and returns to IDLE; the request is lost.
- Reset values:
  - `INT`=0, `vec_id`=0, `in_service`=0.
  - `pending`=0, `irq_d`=0.
  - `mask`=all ones (all sources disabled).
  - FSM=IDLE, round-robin pointer=N-1.

## Timing
- Edge at `irq_in` sampled at edge k: `pending` is set at k. If the FSM is in IDLE and the source is unmasked, `INT`=1 and `vec_id` are valid after edge k+1.
- Pending-to-INT latency is 1 cycle. Input-rise-to-INT latency is 2 edges.
- `Inta` sampled high at edge m: `INT`=0 after m, and `in_service`=1 after m.
- `eoi` at edge e: the FSM is in IDLE after e. A new `INT` can assert after e+1 if a source is eligible, so the minimum gap after EOI is 1 idle cycle.
- A `mask_we` at edge k affects the IDLE decision taken at edge k+1.
- `vec_id` holds its value from grant until the next grant; it is not cleared on EOI.

## Configuration
- `INTR_ARB_RR_EN` defined:
  - Arbitration is round-robin over eligible sources, searching from pointer+1 modulo N.
  - The pointer is loaded with `vec_id` at `Inta` acceptance.
  - At reset the pointer is N-1, so the first search starts at index 0.
- `INTR_ARB_RR_EN` undefined: fixed lowest-index priority, and no pointer register exists.

## Test plan
- Reset, then write `mask`=8'h00 and pulse `irq_in[3]` → after 2 edges `INT`=1 and `vec_id`=3. Assert `Inta` → next cycle `INT`=0, `in_service`=1, `pending`=8'h00. Pulse `eoi` → `in_service`=0.
- With `mask`=8'hFF, pulse `irq_in[5]` → `pending`=8'h20 and `INT` stays 0. Write `mask`=8'hDF → `INT`=1 and `vec_id`=5 one cycle after the write edge.
- Raise `irq_in[1]` and `irq_in[6]` together with mask 0. In the default build the grants are 1 then 6 across two EOI cycles. With RR, after a grant of 1, raise 1 and 6 again → the next grant is 6.
- During SERVICE of source 2, pulse `irq_in[2]` → `pending[2]`=1 with `INT` low. After `eoi` → `INT`=1 with `vec_id`=2.
- Pulse `eoi` and `Inta` while IDLE with no pending → no state change and `INT`=0. Assert `reset` during REQ → `INT`=0 and `pending`=0 next cycle.
- Hold `irq_in[0]` high for 10 cycles → exactly one pending set, because a level is not an edge.

Source files
------------

// File: rtl/intr_arbiter_if.sv
// ============================================================================
//  intr_arbiter_if : request, mask, EOI and CPU handshake signals of intr_arbiter
//  Revision 1.0
// ============================================================================
`default_nettype none

interface intr_arbiter_if #(
    parameter int N   = 8,
    parameter int IDW = 3
);
    logic [N-1:0]   irq_in;
    logic           mask_we;
    logic [N-1:0]   mask_wdata;
    logic           eoi;
    logic           Inta;
    logic           INT;
    logic [IDW-1:0] vec_id;
    logic           in_service;
    logic [N-1:0]   pending;
    logic [N-1:0]   mask;

    modport master (
        output irq_in, mask_we, mask_wdata, eoi, Inta,
        input  INT, vec_id, in_service, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, eoi, Inta,
        output INT, vec_id, in_service, pending, mask
    );
endinterface

`default_nettype wire

// File: rtl/intr_arbiter.sv
// ============================================================================
//  intr_arbiter : edge-detecting, maskable N-source interrupt controller with a
//  single INT/Inta handshake and EOI blocking. IDW must equal clog2(N).
//  Optional macro INTR_ARB_RR_EN selects round-robin arbitration.
//  Revision 1.0
// ============================================================================
`default_nettype none

module intr_arbiter #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    intr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_irq_d;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_mask;
    logic           r_int;
    logic           r_in_service;
    logic [IDW-1:0] r_vec_id;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_eligible;
    logic [N-1:0]   w_clear;
    logic           w_ack;
    logic           w_found;
    logic [IDW-1:0] w_winner;

    assign w_edge     = bus.irq_in & ~r_irq_d;
    assign w_eligible = r_pending & ~r_mask;
    assign w_ack      = (r_state == S_REQ) && bus.Inta;

    always_comb begin
        w_clear = '0;
        if (w_ack) begin
            w_clear[r_vec_id] = 1'b1;
        end
    end

`ifdef INTR_ARB_RR_EN
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_start;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;

    // Rotate so bit 0 of w_rot is the source right after the pointer.
    assign w_start = (r_rr_ptr == IDW'(N - 1)) ? '0 : r_rr_ptr + IDW'(1);
    assign w_rot   = N'({w_eligible, w_eligible} >> w_start);

    always_comb begin
        w_found  = 1'b0;
        w_off    = '0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IDW'(k);
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (IDW + 1)'(N)) begin
            w_sum = w_sum - (IDW + 1)'(N);
        end
        w_winner = w_sum[IDW-1:0];
    end
`else
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_eligible[k]) begin
                w_found  = 1'b1;
                w_winner = IDW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_irq_d      <= '0;
            r_pending    <= '0;
            r_mask       <= '1;
            r_int        <= 1'b0;
            r_in_service <= 1'b0;
            r_vec_id     <= '0;
`ifdef INTR_ARB_RR_EN
            r_rr_ptr     <= IDW'(N - 1);
`endif
        end else begin
            r_irq_d <= bus.irq_in;
            // A fresh edge on the bit being acknowledged keeps it pending.
            r_pending <= (r_pending & ~w_clear) | w_edge;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_vec_id <= w_winner;
                        r_int    <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.Inta) begin
                        r_int        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
`ifdef INTR_ARB_RR_EN
                        r_rr_ptr     <= r_vec_id;
`endif
                    end
                end
                S_SERVICE: begin
                    if (bus.eoi) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_int   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.INT        = r_int;
    assign bus.vec_id     = r_vec_id;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;
    assign bus.mask       = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_intr_arbiter.sv
// ============================================================================
//  tb_intr_arbiter : directed stimulus with a grant scoreboard and snapshot
//  queue, checked by an independent negedge monitor.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_intr_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    intr_arbiter_if #(.N(8), .IDW(3)) bus ();

    intr_arbiter #(.N(8), .IDW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string name;
        logic  int_e;
        int    vec_e;
        int    pend_e;
        logic  insvc_e;
        int    mask_e;
    } snap_t;

    snap_t snap_q[$];
    int    grant_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  prev_int = 1'b0;

    // Monitor: every rising INT must match the next expected grant; queued
    // snapshots are compared at the negedge following their push.
    always @(negedge clk) begin
        if (bus.INT && !prev_int) begin
            checks++;
            if (grant_q.size() == 0) begin
                failures++;
                $display("FAIL grant: unexpected INT with vec_id=%0d, none expected", bus.vec_id);
            end else begin
                int g;
                g = grant_q.pop_front();
                if (int'(bus.vec_id) != g) begin
                    failures++;
                    $display("FAIL grant: vec_id=%0d expected %0d", bus.vec_id, g);
                end
            end
        end
        prev_int = bus.INT;
        while (snap_q.size() > 0) begin
            snap_t e;
            logic  bad;
            e   = snap_q.pop_front();
            bad = (bus.INT !== e.int_e) ||
                  (e.vec_e >= 0 && int'(bus.vec_id) != e.vec_e) ||
                  (bus.pending !== e.pend_e[7:0]) ||
                  (bus.in_service !== e.insvc_e) ||
                  (e.mask_e >= 0 && bus.mask !== e.mask_e[7:0]);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s: got INT=%0b vec=%0d pend=%02h insvc=%0b mask=%02h; want INT=%0b vec=%0d pend=%02h insvc=%0b mask=%0d",
                         e.name, bus.INT, bus.vec_id, bus.pending, bus.in_service, bus.mask,
                         e.int_e, e.vec_e, e.pend_e, e.insvc_e, e.mask_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string n, input logic i, input int v, input int p,
                        input logic s, input int m);
        snap_t e;
        e.name = n; e.int_e = i; e.vec_e = v; e.pend_e = p; e.insvc_e = s; e.mask_e = m;
        snap_q.push_back(e);
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        step();
        bus.mask_we    = 1'b0;
    endtask

    task automatic service();
        bus.Inta = 1'b1; step(); bus.Inta = 1'b0;
        bus.eoi  = 1'b1; step(); bus.eoi  = 1'b0;
    endtask

    int g1, g2;

    initial begin
`ifdef INTR_ARB_RR_EN
        g1 = 6; g2 = 1;
`else
        g1 = 1; g2 = 6;
`endif
        bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.eoi = 1'b0; bus.Inta = 1'b0;
        step(); step();
        reset = 1'b0;
        snap("reset", 0, 0, 8'h00, 0, 8'hFF);

        // Basic grant of source 3
        write_mask(8'h00);
        grant_q.push_back(3);
        bus.irq_in = 8'h08; step(); bus.irq_in = '0;
        snap("t1_pend", 0, -1, 8'h08, 0, 8'h00);
        step();
        snap("t1_int", 1, 3, 8'h08, 0, -1);
        bus.Inta = 1'b1; step(); bus.Inta = 1'b0;
        snap("t1_ack", 0, 3, 8'h00, 1, -1);
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        snap("t1_eoi", 0, 3, 8'h00, 0, -1);

        // Masked source stays pending, unmasking releases it
        write_mask(8'hFF);
        bus.irq_in = 8'h20; step(); bus.irq_in = '0;
        step(); step();
        snap("t2_masked", 0, 3, 8'h20, 0, 8'hFF);
        grant_q.push_back(5);
        write_mask(8'hDF);
        snap("t2_wr_edge", 0, 3, 8'h20, 0, 8'hDF);
        step();
        snap("t2_int", 1, 5, 8'h20, 0, -1);
        service();

        // Simultaneous requests 1 and 6, twice
        write_mask(8'h00);
        grant_q.push_back(g1); grant_q.push_back(g2);
        bus.irq_in = 8'h42; step(); bus.irq_in = '0;
        snap("t3_pend", 0, -1, 8'h42, 0, 8'h00);
        step();
        snap("t3_first", 1, g1, 8'h42, 0, -1);
        bus.Inta = 1'b1; step(); bus.Inta = 1'b0;
        snap("t3_ack1", 0, g1, 8'h42 & ~(1 << g1), 1, -1);
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        snap("t3_gap", 0, g1, 8'h42 & ~(1 << g1), 0, -1);
        step();
        snap("t3_second", 1, g2, 8'h42 & ~(1 << g1), 0, -1);
        service();
        grant_q.push_back(g1); grant_q.push_back(g2);
        bus.irq_in = 8'h42; step(); bus.irq_in = '0;
        step();
        snap("t3_third", 1, g1, 8'h42, 0, -1);
        service();
        step();
        snap("t3_fourth", 1, g2, 8'h42 & ~(1 << g1), 0, -1);
        service();

        // New edge on the in-service source waits for EOI
        grant_q.push_back(2);
        bus.irq_in = 8'h04; step(); bus.irq_in = '0;
        step();
        bus.Inta = 1'b1; step(); bus.Inta = 1'b0;
        bus.irq_in = 8'h04; step(); bus.irq_in = '0;
        snap("t4_insvc_pend", 0, 2, 8'h04, 1, -1);
        grant_q.push_back(2);
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        snap("t4_eoi", 0, 2, 8'h04, 0, -1);
        step();
        snap("t4_regrant", 1, 2, 8'h04, 0, -1);
        service();

        // Stray eoi/Inta in IDLE are ignored
        bus.eoi = 1'b1; bus.Inta = 1'b1; step(); bus.eoi = 1'b0; bus.Inta = 1'b0;
        snap("t5_stray", 0, 2, 8'h00, 0, 8'h00);
        step();
        snap("t5_stray2", 0, 2, 8'h00, 0, 8'h00);

        // Reset during REQ
        grant_q.push_back(0);
        bus.irq_in = 8'h01; step(); bus.irq_in = '0;
        step();
        snap("t5_req", 1, 0, 8'h01, 0, -1);
        reset = 1'b1; step(); reset = 1'b0;
        snap("t5_reset", 0, 0, 8'h00, 0, 8'hFF);

        // A held level produces a single request
        write_mask(8'h00);
        grant_q.push_back(0);
        bus.irq_in = 8'h01; step();
        step();
        bus.Inta = 1'b1; step(); bus.Inta = 1'b0;
        repeat (7) step();
        snap("t6_level", 0, 0, 8'h00, 1, -1);
        bus.irq_in = '0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        step();
        snap("t6_after", 0, 0, 8'h00, 0, -1);

        // Set beats clear on the acknowledged bit
        grant_q.push_back(4);
        bus.irq_in = 8'h10; step(); bus.irq_in = '0;
        step();
        bus.irq_in = 8'h10; bus.Inta = 1'b1; step(); bus.irq_in = '0; bus.Inta = 1'b0;
        snap("t7_setwins", 0, 4, 8'h10, 1, -1);
        grant_q.push_back(4);
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        step();
        snap("t7_regrant", 1, 4, 8'h10, 0, -1);
        service();
        step();
        snap("t7_done", 0, 4, 8'h00, 0, -1);

        step();
        @(negedge clk); #1;
        checks++;
        if (grant_q.size() != 0) begin
            failures++;
            $display("FAIL grants_left: %0d expected grants never seen, want 0", grant_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
